// File: rtl/calc_pkg.sv
// Shared constants and opcode decoding for the calculator entry front end.
// Optional macro OP_DIV_EN: sw_op=11 decodes to divide instead of being rejected.
package calc_pkg;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_DIV  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  localparam logic [1:0] S_A     = 2'b00;
  localparam logic [1:0] S_B     = 2'b01;
  localparam logic [1:0] S_ISSUE = 2'b10;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef struct packed {
    logic       ok;
    logic [2:0] code;
  } op_dec_t;

  function automatic op_dec_t op_decode(input logic [1:0] sw_op);
    op_dec_t d;
    d.ok = 1'b1;
    case (sw_op)
      2'b00:   d.code = OP_ADD;
      2'b01:   d.code = OP_SUB;
      2'b10:   d.code = OP_MUL;
      default: begin
`ifdef OP_DIV_EN
        d.code = OP_DIV;
`else
        d.code = OP_NONE;
        d.ok   = 1'b0;
`endif
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop sync -> counter debouncer -> registered rising-edge pulse.
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int CW = $clog2(DEB_CYCLES) + 1;

  logic          s1, s2, level, level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      pulse   <= 1'b0;
      cnt     <= '0;
    end else begin
      s1      <= btn;
      s2      <= s1;
      level_q <= level;
      pulse   <= level & ~level_q;
      // any sample agreeing with the accepted level restarts the run
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/calc_input_ctrl.sv
// Button-driven BCD operand/opcode entry with a valid/ready tuple handoff.
// OP_DIV_EN (see calc_pkg) enables the divide opcode on sw_op=11.
module calc_input_ctrl
  import calc_pkg::*;
#(
  parameter int N_DIGITS   = 2,
  parameter int DEB_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            sw_val,
  input  logic [1:0]            sw_op,
  input  logic                  btn_enter,
  input  logic                  btn_next,
  input  logic                  btn_clear,
  output logic [4*N_DIGITS-1:0] num1_bcd,
  output logic [4*N_DIGITS-1:0] num2_bcd,
  output logic [2:0]            operation,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  entry_err,
  output logic [1:0]            state_dbg
);

  localparam int W  = 4 * N_DIGITS;
  localparam int CW = $clog2(N_DIGITS + 1);

  logic          enter_p, next_p, clear_p;
  logic [1:0]    state;
  logic [CW-1:0] digit_cnt;
  logic [W-1:0]  shift_a, shift_b;
  logic          digit_ok;
  op_dec_t       dec;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_enter (.clk(clk), .rst_n(rst_n), .btn(btn_enter), .pulse(enter_p));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_next  (.clk(clk), .rst_n(rst_n), .btn(btn_next),  .pulse(next_p));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clear (.clk(clk), .rst_n(rst_n), .btn(btn_clear), .pulse(clear_p));

  // new digit enters at the LSD; the MSD falls off (never reached: count guards it)
  assign shift_a   = W'({num1_bcd, sw_val});
  assign shift_b   = W'({num2_bcd, sw_val});
  assign digit_ok  = (sw_val <= BCD_MAX) && (digit_cnt != CW'(N_DIGITS));
  assign dec       = op_decode(sw_op);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n || clear_p) begin
      state     <= S_A;
      num1_bcd  <= '0;
      num2_bcd  <= '0;
      operation <= OP_NONE;
      digit_cnt <= '0;
      out_valid <= 1'b0;
      entry_err <= 1'b0;
    end else begin
      case (state)
        S_A, S_B: begin
          if (next_p) begin
            if (state == S_B) begin
              state     <= S_ISSUE;
              out_valid <= 1'b1;
            end else if (dec.ok) begin
              operation <= dec.code;
              state     <= S_B;
              digit_cnt <= '0;
            end else begin
              entry_err <= 1'b1;
            end
          end else if (enter_p) begin
            if (digit_ok) begin
              if (state == S_A) num1_bcd <= shift_a;
              else              num2_bcd <= shift_b;
              digit_cnt <= digit_cnt + CW'(1);
              entry_err <= 1'b0;
            end else begin
              entry_err <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          // operation stays latched so the display can keep showing it
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= S_A;
            num1_bcd  <= '0;
            num2_bcd  <= '0;
            digit_cnt <= '0;
          end
        end
        default: state <= S_A;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_input_ctrl.sv
// Scoreboard bench for calc_input_ctrl: DEB_CYCLES=4, N_DIGITS=2.
module tb_calc_input_ctrl;

  localparam int DEB = 4;
  localparam int ND  = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      sw_val;
  logic [1:0]      sw_op;
  logic            btn_enter, btn_next, btn_clear;
  logic [4*ND-1:0] num1_bcd, num2_bcd;
  logic [2:0]      operation;
  logic            out_valid, out_ready, entry_err;
  logic [1:0]      state_dbg;

  calc_input_ctrl #(.N_DIGITS(ND), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .sw_val(sw_val), .sw_op(sw_op),
    .btn_enter(btn_enter), .btn_next(btn_next), .btn_clear(btn_clear),
    .num1_bcd(num1_bcd), .num2_bcd(num2_bcd), .operation(operation),
    .out_valid(out_valid), .out_ready(out_ready), .entry_err(entry_err),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4*ND-1:0] a;
    logic [4*ND-1:0] b;
    logic [2:0]      op;
  } tup_t;

  tup_t sbq[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic e, input logic nx, input logic c);
    btn_enter = e; btn_next = nx; btn_clear = c;
    tick(DEB + 6);
    btn_enter = 1'b0; btn_next = 1'b0; btn_clear = 1'b0;
    tick(DEB + 6);
  endtask

  task automatic enter(input logic [3:0] v);
    sw_val = v;
    press(1'b1, 1'b0, 1'b0);
  endtask

  task automatic nxt(input logic [1:0] op);
    sw_op = op;
    press(1'b0, 1'b1, 1'b0);
  endtask

  task automatic clr();
    press(1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_n1"},  num1_bcd,  0);
    chk({tag, "_n2"},  num2_bcd,  0);
    chk({tag, "_op"},  operation, 0);
    chk({tag, "_vld"}, out_valid, 0);
    chk({tag, "_err"}, entry_err, 0);
    chk({tag, "_st"},  state_dbg, 0);
  endtask

  // wait for the tuple, compare against the scoreboard head, then accept it
  task automatic drain();
    int   t;
    tup_t e;
    t = 0;
    while (!out_valid && t < 50) begin tick(1); t++; end
    chk("hs_valid", out_valid, 1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("hs_n1", num1_bcd,  e.a);
      chk("hs_n2", num2_bcd,  e.b);
      chk("hs_op", operation, e.op);
    end
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    chk("hs_vld_drop", out_valid, 0);
    chk("hs_st",       state_dbg, 0);
    chk("hs_n1_clr",   num1_bcd,  0);
    chk("hs_op_keep",  operation, e.op);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    tup_t e;
    rst_n = 1'b0; sw_val = '0; sw_op = '0;
    btn_enter = 1'b0; btn_next = 1'b0; btn_clear = 1'b0; out_ready = 1'b0;
    tick(3);
    chk_zero("rst");
    rst_n = 1'b1;
    tick(2);

    // basic add tuple
    enter(4'd4); enter(4'd7);
    chk("a_n1", num1_bcd, 8'h47);
    nxt(2'b00);
    chk("a_st", state_dbg, 1);
    chk("a_op", operation, 3'b010);
    enter(4'd1); enter(4'd2);
    sbq.push_back('{a: 8'h47, b: 8'h12, op: 3'b010});
    nxt(2'b00);
    chk("a_st_issue", state_dbg, 2);
    drain();

    // bad digit then good digit
    clr();
    enter(4'd11);
    chk("bad_err", entry_err, 1);
    chk("bad_n1",  num1_bcd,  0);
    enter(4'd3);
    chk("good_err", entry_err, 0);
    chk("good_n1",  num1_bcd,  8'h03);
    clr();

    // digit overflow
    enter(4'd1); enter(4'd2); enter(4'd3);
    chk("ovf_n1",  num1_bcd,  8'h12);
    chk("ovf_err", entry_err, 1);
    clr();
    chk_zero("clr1");

    // sw_op=11
    nxt(2'b11);
`ifdef OP_DIV_EN
    chk("div_st",  state_dbg, 1);
    chk("div_op",  operation, 3'b110);
    chk("div_err", entry_err, 0);
`else
    chk("inv_st",  state_dbg, 0);
    chk("inv_err", entry_err, 1);
    chk("inv_op",  operation, 0);
`endif
    clr();

    // sub tuple held in issue while inputs wiggle, then cleared
    enter(4'd5); nxt(2'b01); enter(4'd9);
    sbq.push_back('{a: 8'h05, b: 8'h09, op: 3'b100});
    nxt(2'b10);
    e = sbq[0];
    for (int i = 0; i < 10; i++) begin
      sw_val = 4'($urandom_range(0, 9));
      btn_enter = ~btn_enter;
      tick(1);
      chk("hold_vld", out_valid, 1);
      chk("hold_n1",  num1_bcd,  e.a);
      chk("hold_n2",  num2_bcd,  e.b);
      chk("hold_op",  operation, e.op);
    end
    btn_enter = 1'b0;
    enter(4'd2);
    nxt(2'b00);
    chk("hold2_n2", num2_bcd,  e.b);
    chk("hold2_op", operation, e.op);
    chk("hold2_st", state_dbg, 2);
    clr();
    void'(sbq.pop_front());
    chk_zero("issue_clr");

    // clear beats enter in the same cycle
    enter(4'd6);
    chk("pri_pre", num1_bcd, 8'h06);
    sw_val = 4'd7;
    press(1'b1, 1'b0, 1'b1);
    chk("pri_n1", num1_bcd, 0);

    // short glitch is filtered
    sw_val = 4'd5;
    btn_enter = 1'b1; tick(2); btn_enter = 1'b0;
    tick(20);
    chk("glitch_n1", num1_bcd, 0);

    // reset mid-entry
    enter(4'd8); enter(4'd12);
    chk("pre_rst_n1",  num1_bcd,  8'h08);
    chk("pre_rst_err", entry_err, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_zero("mid_rst");
    tick(1);
    rst_n = 1'b1;
    tick(2);
    enter(4'd3);
    chk("post_rst_n1", num1_bcd, 8'h03);

    // second full tuple: mul
    nxt(2'b10); enter(4'd9); enter(4'd0);
    sbq.push_back('{a: 8'h03, b: 8'h90, op: 3'b111});
    nxt(2'b00);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/calc_input_ctrl.md
Name: calc_input_ctrl

Overview:
Sequential operand/opcode entry front end for the lab calculator datapath. It replaces the purely combinational switch-to-BCD mapping with debounced button-driven digit entry. Multi-digit BCD operands are built one digit at a time, and the opcode is latched. A complete {num1, num2, operation} tuple is presented to the ALU/display stage with a valid/ready handshake.

Parameters:
- N_DIGITS, 2, BCD digits per operand (1..4); operand width = 4*N_DIGITS.
- DEB_CYCLES, 16, consecutive stable samples before a button level is accepted. The board top overrides this to about 25 ms worth of cycles.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- sw_val  in  4  digit switches (binary 0-15).
- sw_op  in  2  operation switches.
- btn_enter  in  1  raw push-button: push sw_val digit into the current operand.
- btn_next  in  1  raw push-button: advance A->B (latching opcode), then B->issue.
- btn_clear  in  1  raw push-button: abort and zero everything.
- num1_bcd  out  4*N_DIGITS  operand A, packed BCD, LSD in [3:0].
- num2_bcd  out  4*N_DIGITS  operand B, packed BCD.
- operation  out  3  opcode: 010 add, 100 sub, 111 mul, 000 none.
- out_valid  out  1  tuple complete and stable.
- out_ready  in  1  downstream accepts the tuple.
- entry_err  out  1  sticky error flag (bad digit, digit overflow, invalid op).
- state_dbg  out  2  current FSM state, for LEDs.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs are 0 and the FSM is in S_A.
  - Digit counter and debouncer counters are 0.
  - Debounced button levels are 0.
- Buttons:
  - Each raw button passes through a 2-flop synchronizer, then a debouncer.
  - A debounced level changes only after DEB_CYCLES identical consecutive samples.
  - A rising edge of a debounced level produces a 1-cycle pulse (enter_p, next_p, clear_p).
  - Latency from a stable raw press to the pulse is DEB_CYCLES+3 cycles.
- Priority within a cycle: clear_p > next_p > enter_p. A lower-priority pulse in the same cycle is discarded.
- FSM states: S_A=00, S_B=01, S_ISSUE=10.
- enter_p in S_A or S_B:
  - If sw_val<=9 and digit_cnt<N_DIGITS: the current operand becomes {operand[4*N_DIGITS-5:0], sw_val}, digit_cnt increments, and entry_err clears.
  - If sw_val>9: the digit is dropped and entry_err is set.
  - If digit_cnt==N_DIGITS: the digit is dropped and entry_err is set.
- next_p in S_A:
  - sw_op maps 00->010, 01->100, 10->111 into operation.
  - On a valid mapping: go to S_B and reset digit_cnt to 0.
  - sw_op=11 is invalid: entry_err is set and the FSM stays in S_A.
- next_p in S_B: go to S_ISSUE. out_valid=1 from the next cycle.
- S_ISSUE:
  - num1_bcd, num2_bcd and operation are held constant; enter_p and next_p are ignored.
  - On a cycle with out_valid && out_ready: out_valid drops next cycle, the FSM returns to S_A, operands and digit_cnt clear, and operation is retained until the next latch.
- clear_p in any state, including mid-handshake:
  - Next cycle: S_A, both operands 0, operation 000, digit_cnt 0, out_valid 0, entry_err 0.
- Synchronous reset mid-entry behaves exactly as clear, and also clears the debouncers.
- An empty operand (no digits entered) is legal and equals 0.

Optional Feature:
- Macro OP_DIV_EN.
  - Defined: sw_op=11 maps to operation 110 (divide) and is a valid latch.
  - Undefined: sw_op=11 is invalid, sets entry_err and blocks advance.

Decomposition:
- Package calc_pkg holds:
  - opcode constants OP_NONE=000, OP_ADD=010, OP_SUB=100, OP_DIV=110, OP_MUL=111;
  - FSM state encodings S_A, S_B, S_ISSUE;
  - the BCD digit max constant 9.
- Sub-module btn_debounce (parameter DEB_CYCLES; sync + debounce + rise pulse) is instantiated three times.

Test Plan:
- DEB_CYCLES=4, N_DIGITS=2, no OP_DIV_EN. Enter 4, 7; next with sw_op=00; enter 1, 2; next -> num1_bcd=0x47, num2_bcd=0x12, operation=010, out_valid=1; out_ready=1 for 1 cycle -> out_valid=0, state_dbg=00.
- Enter sw_val=11 in S_A -> entry_err=1, num1_bcd unchanged; then enter 3 -> entry_err=0, num1_bcd=0x03.
- Enter 1, 2, 3 with N_DIGITS=2 -> num1_bcd=0x12, entry_err=1.
- next with sw_op=11 -> stays S_A, entry_err=1. Repeat with OP_DIV_EN defined -> S_B, operation=110.
- Reach S_ISSUE with out_ready=0 for 10 cycles and toggle sw_val/enter -> outputs stable. Assert clear -> out_valid=0, all zero.
- Raw btn_enter glitch of 2 cycles (<DEB_CYCLES) -> no digit accepted. Assert rst_n=0 mid-entry -> all outputs 0 at next edge.
